// File: rtl/tetris_input_pkg.sv
// Shared definitions for the Tetris input path: button indices, event code
// width and the hold-to-repeat state encoding.
package tetris_input_pkg;

   localparam int NUM_BTN    = 5;
   localparam int BTN_LEFT   = 0;
   localparam int BTN_RIGHT  = 1;
   localparam int BTN_ROTATE = 2;
   localparam int BTN_DOWN   = 3;
   localparam int BTN_DROP   = 4;

   localparam int EVT_CODE_W = $clog2(NUM_BTN);

   typedef enum logic [1:0] {
      REP_IDLE   = 2'd0,
      REP_DELAY  = 2'd1,
      REP_REPEAT = 2'd2
   } rep_state_t;

endpackage

// File: rtl/event_fifo.sv
// First-word-fall-through FIFO; head word is visible combinationally and a
// push into a full FIFO is accepted when a pop happens in the same cycle.
module event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             push_fire;
   logic             pop_fire;

   assign empty     = (count_reg == '0);
   assign full      = (count_reg == (AW+1)'(DEPTH));
   assign pop_fire  = pop && !empty;
   assign push_fire = push && (!full || pop_fire);
   assign pop_data  = mem[rd_ptr_reg];
   assign count     = count_reg;

   // Storage is deliberately not reset; the head is ignored while empty.
   always_ff @(posedge clk) begin
      if (push_fire) mem[wr_ptr_reg] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_fire) wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
         case ({push_fire, pop_fire})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/input_event_queue.sv
// Serialises debounced button press pulses into an ordered event FIFO.
// Hold-to-repeat is compiled in with INPUT_QUEUE_AUTOREPEAT_EN.
module input_event_queue #(
   parameter int                 NUM_BTN      = tetris_input_pkg::NUM_BTN,
   parameter int                 DEPTH        = 4,
   parameter logic [NUM_BTN-1:0] REPEAT_MASK  = 5'b01011,
   parameter int                 REPEAT_DELAY = 25_000_000,
   parameter int                 REPEAT_RATE  = 5_000_000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_BTN-1:0]         btn_raise,
   input  logic [NUM_BTN-1:0]         btn_held,
   output logic                       evt_valid,
   output logic [$clog2(NUM_BTN)-1:0] evt_code,
   input  logic                       evt_ready,
   output logic                       drop_pulse,
   output logic [7:0]                 drop_cnt
);

   import tetris_input_pkg::*;

   localparam int CW = $clog2(NUM_BTN);
   localparam int AW = $clog2(DEPTH);

   logic [NUM_BTN-1:0] pending_reg, pending_next;
   logic [NUM_BTN-1:0] raise_all, inject, merged, push_onehot;
   logic [CW-1:0]      sel;
   logic               push, pop_fire;
   logic               fifo_full, fifo_empty;
   logic [AW:0]        fifo_count;
   logic [7:0]         merge_n;
   logic [8:0]         drop_sum;
   logic [7:0]         drop_cnt_reg, drop_cnt_next;
   logic               drop_pulse_reg;

   event_fifo #(.DEPTH(DEPTH), .WIDTH(CW)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (sel),
      .pop       (evt_ready),
      .pop_data  (evt_code),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign evt_valid = (fifo_count != '0);
   assign pop_fire  = evt_ready && !fifo_empty;
   assign push      = (|pending_reg) && (!fifo_full || pop_fire);

   always_comb begin
      sel = '0;
      for (int i = NUM_BTN-1; i >= 0; i--) begin
         if (pending_reg[i]) sel = CW'(i);
      end
   end

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_onehot
      assign push_onehot[gi] = push && (sel == CW'(gi));
   end

   // A bit pushed this cycle is free again, so a coincident press re-arms it.
   always_comb begin
      raise_all    = btn_raise | inject;
      merged       = raise_all & pending_reg & ~push_onehot;
      pending_next = (pending_reg & ~push_onehot) | raise_all;
      merge_n      = '0;
      for (int i = 0; i < NUM_BTN; i++) merge_n = merge_n + 8'(merged[i]);
      drop_sum      = {1'b0, drop_cnt_reg} + {1'b0, merge_n};
      drop_cnt_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pending_reg    <= '0;
         drop_cnt_reg   <= '0;
         drop_pulse_reg <= 1'b0;
      end else begin
         pending_reg    <= pending_next;
         drop_cnt_reg   <= drop_cnt_next;
         drop_pulse_reg <= |merged;
      end
   end

   assign drop_cnt   = drop_cnt_reg;
   assign drop_pulse = drop_pulse_reg;

`ifdef INPUT_QUEUE_AUTOREPEAT_EN
   localparam int RCW = $clog2((REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE);

   rep_state_t         state_reg, state_next;
   logic [CW-1:0]      rep_idx_reg, rep_idx_next;
   logic [RCW-1:0]     rep_cnt_reg, rep_cnt_next;
   logic [NUM_BTN-1:0] rep_hit;

   // A fresh eligible press always restarts tracking, even mid-repeat.
   always_comb begin
      state_next   = state_reg;
      rep_idx_next = rep_idx_reg;
      rep_cnt_next = rep_cnt_reg;
      inject       = '0;
      rep_hit      = btn_raise & REPEAT_MASK;
      if (|rep_hit) begin
         for (int i = NUM_BTN-1; i >= 0; i--) begin
            if (rep_hit[i]) rep_idx_next = CW'(i);
         end
         rep_cnt_next = RCW'(REPEAT_DELAY - 1);
         state_next   = REP_DELAY;
      end else if (state_reg != REP_IDLE) begin
         if (!btn_held[rep_idx_reg]) begin
            state_next = REP_IDLE;
         end else if (rep_cnt_reg == '0) begin
            inject[rep_idx_reg] = 1'b1;
            rep_cnt_next        = RCW'(REPEAT_RATE - 1);
            state_next          = REP_REPEAT;
         end else begin
            rep_cnt_next = rep_cnt_reg - RCW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg   <= REP_IDLE;
         rep_idx_reg <= '0;
         rep_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         rep_idx_reg <= rep_idx_next;
         rep_cnt_reg <= rep_cnt_next;
      end
   end
`else
   logic unused_cfg;
   assign inject     = '0;
   assign unused_cfg = ^{btn_held, REPEAT_MASK, REPEAT_DELAY, REPEAT_RATE};
`endif

endmodule

// File: tb/tb_input_event_queue.sv
// Scoreboard bench for input_event_queue: stimulus queues expected codes,
// a negedge monitor checks each accepted event in order.
module tb_input_event_queue;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [4:0] btn_raise = '0;
   logic [4:0] btn_held = '0;
   logic       evt_ready = 1'b0;
   logic       evt_valid;
   logic [2:0] evt_code;
   logic       drop_pulse;
   logic [7:0] drop_cnt;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int exp_q[$];
   int pop_cyc[$];

   input_event_queue #(
      .NUM_BTN(5), .DEPTH(4), .REPEAT_MASK(5'b01011),
      .REPEAT_DELAY(10), .REPEAT_RATE(4)
   ) dut (
      .clk(clk), .reset(reset), .btn_raise(btn_raise), .btn_held(btn_held),
      .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end else begin
         $display("[TB] ok %s = %0d", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check({name, "_drained_left"}, exp_q.size(), 0);
   endtask

   // Monitor: every accepted event must match the oldest expected code.
   always @(negedge clk) begin
      int e;
      if (reset && evt_valid && evt_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_event: got code %0d, required no event", evt_code);
         end else begin
            e = exp_q.pop_front();
            check("event_code", int'(evt_code), e);
         end
         pop_cyc.push_back(cyc);
      end
   end

   initial begin
      int base;
      int k;
      int rel[6];

      // Reset state
      repeat (3) tick();
      check("rst_valid", evt_valid, 0);
      check("rst_drop_cnt", drop_cnt, 0);
      check("rst_drop_pulse", drop_pulse, 0);
      reset = 1'b1;
      tick();

      // 1. Single press: valid exactly one cycle, two edges after the pulse
      evt_ready = 1'b1;
      btn_raise = 5'b00100; exp_q.push_back(2);
      tick();
      btn_raise = '0;
      check("t1_valid_after_k", evt_valid, 0);
      tick();
      check("t1_valid_after_k1", evt_valid, 1);
      check("t1_code", evt_code, 2);
      tick();
      check("t1_valid_after_k2", evt_valid, 0);

      // 2. Simultaneous presses drain lowest index first
      evt_ready = 1'b0;
      btn_raise = 5'b10011;
      exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(4);
      tick();
      btn_raise = '0;
      repeat (4) tick();
      check("t2_count", dut.u_fifo.count_reg, 3);
      check("t2_head", evt_code, 0);
      evt_ready = 1'b1;
      drain("t2", 10);
      check("t2_drop_cnt", drop_cnt, 0);

      // 3. Overflow: code 4 waits pending, its re-press is merged
      evt_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         btn_raise = 5'(1 << c); exp_q.push_back(c);
         tick();
      end
      btn_raise = 5'b10000;
      tick();
      btn_raise = '0;
      check("t3_drop_pulse", drop_pulse, 1);
      check("t3_drop_cnt", drop_cnt, 1);
      tick();
      check("t3_drop_pulse_end", drop_pulse, 0);
      check("t3_full_count", dut.u_fifo.count_reg, 4);
      check("t3_head_stable", evt_code, 0);
      evt_ready = 1'b1;
      tick();
      evt_ready = 1'b0;
      tick();
      check("t3_refill_count", dut.u_fifo.count_reg, 4);
      evt_ready = 1'b1;
      drain("t3", 10);

      // 4. Full FIFO with concurrent push and pop across pointer wrap
      evt_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         btn_raise = 5'(1 << c); exp_q.push_back(c);
         tick();
      end
      check("t4_full", dut.u_fifo.count_reg, 4);
      evt_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         btn_raise = 5'(1 << (i % 5)); exp_q.push_back(i % 5);
         tick();
         check("t4_count_steady", dut.u_fifo.count_reg, 4);
      end
      btn_raise = '0;
      drain("t4", 12);

      // 5. Reset mid-queue discards everything
      evt_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         btn_raise = 5'(1 << c);
         tick();
      end
      btn_raise = '0;
      repeat (2) tick();
      check("t5_count_before", dut.u_fifo.count_reg, 3);
      check("t5_drop_before", drop_cnt, 1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("t5_valid", evt_valid, 0);
      check("t5_drop_cnt", drop_cnt, 0);
      repeat (2) tick();
      check("t5_no_stale", evt_valid, 0);
      base = pop_cyc.size();
      evt_ready = 1'b1;
      btn_raise = 5'b01000; exp_q.push_back(3);
      tick();
      btn_raise = '0;
      drain("t5", 10);
      repeat (2) tick();
      check("t5_event_count", pop_cyc.size() - base, 1);

      // 7. Multi-bit merges and drop counter saturation
      evt_ready = 1'b0;
      btn_raise = 5'b11111;
      for (int c = 0; c < 4; c++) exp_q.push_back(c);
      tick();
      btn_raise = '0;
      repeat (5) tick();
      check("t7_full", dut.u_fifo.count_reg, 4);
      check("t7_drop_zero", drop_cnt, 0);
      btn_raise = 5'b11111;
      for (int c = 0; c < 5; c++) exp_q.push_back(c);
      tick();
      check("t7_single_merge_pulse", drop_pulse, 1);
      check("t7_single_merge_cnt", drop_cnt, 1);
      tick();
      check("t7_five_merge_pulse", drop_pulse, 1);
      check("t7_five_merge_cnt", drop_cnt, 6);
      repeat (49) tick();
      check("t7_cnt_251", drop_cnt, 251);
      tick();
      check("t7_cnt_saturate", drop_cnt, 255);
      tick();
      check("t7_cnt_hold", drop_cnt, 255);
      btn_raise = '0;
      tick();
      check("t7_pulse_clear", drop_pulse, 0);
      evt_ready = 1'b1;
      drain("t7", 15);

`ifdef INPUT_QUEUE_AUTOREPEAT_EN
      // 6. Auto-repeat on button 0, single event on non-repeating button 2
      rel = '{0, 10, 14, 18, 22, 26};
      pop_cyc.delete();
      evt_ready = 1'b1;
      btn_held  = 5'b00001;
      btn_raise = 5'b00001;
      for (int i = 0; i < 6; i++) exp_q.push_back(0);
      tick();
      k = cyc;
      btn_raise = '0;
      repeat (29) tick();
      btn_held = '0;
      repeat (20) tick();
      check("t6_repeat_events", pop_cyc.size(), 6);
      if (pop_cyc.size() > 0) check("t6_first_latency", pop_cyc[0] - k, 1);
      for (int i = 1; i < 6; i++) begin
         if (i < pop_cyc.size()) check("t6_repeat_offset", pop_cyc[i] - pop_cyc[0], rel[i]);
      end
      check("t6_repeat_left", exp_q.size(), 0);
      exp_q.delete();
      pop_cyc.delete();
      btn_held  = 5'b00100;
      btn_raise = 5'b00100; exp_q.push_back(2);
      tick();
      btn_raise = '0;
      repeat (25) tick();
      btn_held = '0;
      repeat (5) tick();
      check("t6_rotate_events", pop_cyc.size(), 1);
`endif

      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/input_event_queue.md
# input_event_queue

Consumer end of the debounced button-pulse interface. Collects one-cycle press pulses from the per-button debouncing circuits and serialises them into an ordered queue of move events. The Tetris game controller pops these events with a valid/ready handshake at its own pace. Presses arriving while the game logic is busy are buffered rather than lost, and an optional hold-to-repeat generator is included.

## Interface
Parameters:
- `NUM_BTN`, 5: number of buttons; index 0 left, 1 right, 2 rotate, 3 down, 4 drop.
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `REPEAT_MASK`, 5'b01011: buttons eligible for auto-repeat (left, right, down).
- `REPEAT_DELAY`, 25_000_000: cycles from press to first repeat (≥2).
- `REPEAT_RATE`, 5_000_000: cycles between subsequent repeats (≥2).

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-low.
- `btn_raise`, in, NUM_BTN: one-cycle press pulses from the debouncers; multiple bits may be set in the same cycle.
- `btn_held`, in, NUM_BTN: debounced button levels; used only when auto-repeat is compiled in.
- `evt_valid`, out, 1: head event available.
- `evt_code`, out, $clog2(NUM_BTN): button index of the head event.
- `evt_ready`, in, 1: consumer accepts the head event.
- `drop_pulse`, out, 1: one-cycle pulse when an event is discarded.
- `drop_cnt`, out, 8: saturating count of discarded events.

## Operation
- **Pending mask.** Each `btn_raise` bit ORs into its bit of `pending[NUM_BTN-1:0]`.
- **Merged presses.** A pulse on a bit that is already pending is merged, not queued. It counts as a drop.
- **Enqueue.** Each cycle, the lowest-index pending bit is encoded and pushed into the FIFO, and that pending bit is cleared.
- **Push condition.** A push happens when `count < DEPTH`, or when a pop occurs in the same cycle.
- **Per-cycle limits.** At most one push and one pop per cycle.
- **Same-cycle pulse and push.** If a bit is pushed in a cycle where its `btn_raise` also fires, the bit stays pending, so the new press queues next.
- **Full FIFO.** `pending` simply holds. Nothing is lost unless a bit is re-pressed while still pending.
- **FIFO output.** First-word-fall-through:
  - `evt_valid = (count != 0)`.
  - `evt_code = mem[rd_ptr]`, stable while `evt_valid && !evt_ready`.
  - Pop on `evt_valid && evt_ready`.
- **Pointers.** `$clog2(DEPTH)` bits and wrap naturally. `count` is `$clog2(DEPTH)+1` bits.
- **Empty FIFO.** `evt_ready` while empty has no effect.
- **Drop accounting.** `drop_cnt` saturates at 255. If two merges occur in one cycle, `drop_pulse` is high once and `drop_cnt` increments by the number of merged bits, still saturating.
- **Reset values.** `reset==0` at a clock edge clears `pending`, the pointers, `count`, the repeat FSM, `drop_cnt`, and `drop_pulse` to 0.
  - `evt_valid` resets to 0.
  - `evt_code` reads `mem[0]` (memory is not cleared); the consumer must ignore it while `evt_valid` is 0.
  - Reset mid-operation discards all queued and pending events.

## Timing
- **Latency.** A pulse sampled at edge k sets `pending` at edge k. It is written at edge k+1, so `evt_valid` is high after edge k+1 when the FIFO was empty: 2 cycles.
- **Throughput.** One event per cycle sustained.
- **Full and popping.** With the FIFO full and `evt_ready` high, push and pop both occur and `count` is unchanged.
- **Drop timing.** `drop_pulse` is registered: high the cycle after the merging pulse.

## Configuration
The macro is `INPUT_QUEUE_AUTOREPEAT_EN`.

When defined, a repeat FSM is compiled in:
- **States.** IDLE, DELAY, REPEAT. One tracked button `rep_idx` and one down-counter.
- **Enter DELAY.** From any state, a `btn_raise` on a `REPEAT_MASK` button (lowest index if several) loads `rep_idx`, loads the counter with `REPEAT_DELAY-1`, and goes to DELAY.
- **DELAY / REPEAT expiry.** When the counter reaches 0, the FSM injects a pulse into `pending[rep_idx]` (merge rules apply), reloads `REPEAT_RATE-1`, and goes to REPEAT.
- **Release.** `btn_held[rep_idx]==0` in DELAY or REPEAT returns to IDLE with no injection that cycle.

When the macro is undefined:
- The FSM is absent and `btn_held` is unused.
- `REPEAT_*` parameters are ignored.

## Structure
- **Shared package `tetris_input_pkg`.** Holds:
  - Button index constants `BTN_LEFT`..`BTN_DROP`.
  - `NUM_BTN`.
  - Event code width.
  - The repeat FSM state enum.
- **Sub-module `event_fifo`.** Parameterised `DEPTH` and `WIDTH`, first-word-fall-through, push/pop/count/full/empty. This module instantiates it once.

## Test plan
Default parameters except as stated; bench uses `DEPTH=4`, `REPEAT_DELAY=10`, `REPEAT_RATE=4`.
1. **Single press.** `btn_raise=5'b00100` for 1 cycle, `evt_ready=1` → `evt_valid` high exactly 1 cycle, 2 cycles later, with `evt_code=2`.
2. **Simultaneous presses.** `btn_raise=5'b10011` in one cycle, `evt_ready=0` → FIFO drains as codes 0, 1, 4 in that order once `evt_ready=1`. No drops.
3. **Overflow.** `evt_ready=0`; press codes 0, 1, 2, 3, 4 one per cycle, then press 4 again → FIFO holds 0..3 and 4 stays pending. The second press of 4 gives `drop_pulse` once and `drop_cnt=1`. Popping one entry lets 4 enter the FIFO.
4. **Concurrent push and pop.** FIFO full, `evt_ready=1` with continuous new presses → `count` stays 4 and order is preserved across pointer wrap.
5. **Reset mid-queue.** Three events queued, `reset=0` for 1 cycle → `evt_valid=0`, `drop_cnt=0`. A subsequent press yields a single correct event.
6. **Auto-repeat (macro defined).** Press and hold button 0 for 30 cycles → events at press+2, then at +10, +14, +18, +22, +26 relative to the first event. Release stops further events. Button 2 held → exactly one event.
